fetch_prefetch_queue: RTL and testbench

//  Decoupled instruction-fetch front end that feeds the IF/ID pipeline register of the 5-stage core.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_prefetch_queue_if.sv | 30 +++
 rtl/fetch_prefetch_queue_fifo.sv | 55 +++++
 rtl/fetch_prefetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants for the fetch front end: widths, reset PC and the
// {pc, instr} layout of a prefetch-queue entry.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int ENTRY_W = XLEN + ILEN;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of imem request/response, redirect and decode-side handshake signals
// for the fetch front end; master is the fetch unit, slave is its environment.
interface fetch_prefetch_queue_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic            empty;
  logic            full;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, empty, full,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, empty, full,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a
// power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is not reset; occupancy alone decides what is meaningful
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled sequential fetch with a {pc, instr} prefetch queue and redirect flush.
// FETCH_BYPASS_EN: forward a live response straight to decode when the queue is empty.
module fetch_prefetch_queue #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input logic                   clk,
  input logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding, discard;
  logic [EW-1:0]   q_head;
  logic [CW-1:0]   q_count;
  logic            q_empty, q_full, q_push, q_pop;
  logic [XLEN-1:0] tag_head;
  logic            tag_full, unused_tag_empty;
  logic            req_fire, rsp_live, have_out;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;
  logic            unused_redirect_lo;

  assign unused_redirect_lo = ^bus.redirect_pc[1:0];
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_live = bus.mem_rsp_valid && (discard == '0) && !bus.redirect_valid;

  // credit counts both buffered entries and live in-flight fetches
  assign bus.mem_req_valid = !reset && !bus.redirect_valid && !tag_full &&
                             (int'(q_count) + int'(outstanding) - int'(discard) < DEPTH);
  assign bus.mem_req_addr  = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      discard  <= outstanding - OW'(bus.mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (bus.mem_rsp_valid && (discard != '0)) discard <= discard - OW'(1);
    end
  end

  // in-order tags of every issued address; its occupancy is the outstanding count
  fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (bus.mem_rsp_valid),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (outstanding),
    .empty     (unused_tag_empty),
    .full      (tag_full)
  );

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = rsp_live && q_empty;
  assign q_push     = rsp_live && !(bypass && bus.out_ready);
  assign have_out   = !q_empty || bypass;
  assign head_pc    = q_empty ? tag_head         : q_head[EW-1:ILEN];
  assign head_instr = q_empty ? bus.mem_rsp_data : q_head[ILEN-1:0];
`else
  assign q_push     = rsp_live;
  assign have_out   = !q_empty;
  assign head_pc    = q_head[EW-1:ILEN];
  assign head_instr = q_head[ILEN-1:0];
`endif

  assign q_pop = bus.out_valid && bus.out_ready && !q_empty;

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({tag_head, bus.mem_rsp_data}),
    .pop       (q_pop),
    .flush     (bus.redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign bus.out_valid    = have_out && !bus.redirect_valid;
  assign bus.out_instr    = have_out ? head_instr : '0;
  assign bus.out_pc       = have_out ? head_pc : '0;
  assign bus.out_pc_plus4 = have_out ? head_pc + XLEN'(4) : '0;
  assign bus.empty        = q_empty;
  assign bus.full         = q_full;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed + randomized bench for fetch_prefetch_queue with an in-order imem
// model and a stream-level expectation of request and decode PC sequences.
module tb_fetch_prefetch_queue;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.XLEN(32)) bus();

  fetch_prefetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;
  int n_out = 0;
  logic [31:0] exp_out_pc, exp_req_pc;
  logic [31:0] last_pc, last_plus4, last_instr;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_full", bus.full, 1'b0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    pend_addr.delete();
    pend_due.delete();
    exp_out_pc = 32'h0;
    exp_req_pc = 32'h0;
    reset = 1'b0;
  endtask

  // drive this cycle's imem response and let combinational outputs settle
  task automatic prep();
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_fn(pend_addr[0]);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  // check the settled cycle against the stream model, then clock it
  task automatic fin();
    logic rfire, ofire;
    logic [31:0] raddr;
    rfire = bus.mem_req_valid && bus.mem_req_ready;
    ofire = bus.out_valid && bus.out_ready;
    raddr = bus.mem_req_addr;
    if (bus.redirect_valid) begin
      chk1("redir_out_valid", bus.out_valid, 1'b0);
      chk1("redir_req_valid", bus.mem_req_valid, 1'b0);
      exp_out_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      exp_req_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (rfire) begin
        chk("req_addr", raddr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (ofire) begin
        chk("out_pc", bus.out_pc, exp_out_pc);
        chk("out_instr", bus.out_instr, mem_fn(exp_out_pc));
        chk("out_pc_plus4", bus.out_pc_plus4, exp_out_pc + 32'd4);
        last_pc    = bus.out_pc;
        last_plus4 = bus.out_pc_plus4;
        last_instr = bus.out_instr;
        n_out++;
        exp_out_pc = exp_out_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    if (bus.mem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (rfire) begin
      pend_addr.push_back(raddr);
      pend_due.push_back(cyc - 1 + lat);
      chk1("max_outstanding", pend_addr.size() <= MAX_OUT, 1'b1);
    end
    #1;
  endtask

  task automatic tick();
    prep();
    fin();
  endtask

  task automatic wait_out(input string tag);
    int n0;
    n0 = n_out;
    for (int i = 0; i < 30 && n_out == n0; i++) tick();
    chk1(tag, n_out != n0, 1'b1);
  endtask

  initial begin
    int  n0;
    logic found;
    bus.out_ready     = 1'b0;
    bus.mem_req_ready = 1'b1;

    // sequential fetch at one instruction per cycle
    lat = 1;
    do_reset();
    bus.out_ready = 1'b1;
    prep();
    chk1("t1_first_req_valid", bus.mem_req_valid, 1'b1);
    chk("t1_first_req_addr", bus.mem_req_addr, 32'h0);
    fin();
    repeat (3) tick();
    n0 = n_out;
    repeat (8) tick();
    chk("t1_rate", n_out - n0, 32'd8);

    // decode stall fills the queue, release drains in order
    do_reset();
    bus.out_ready = 1'b0;
    repeat (10) tick();
    bus.out_ready = 1'b1;
    prep();
    chk1("t2_full", bus.full, 1'b1);
    chk1("t2_req_blocked", bus.mem_req_valid, 1'b0);
    chk1("t2_out_valid", bus.out_valid, 1'b1);
    chk("t2_head_pc", bus.out_pc, 32'h0);
    n0 = n_out;
    fin();
    repeat (3) tick();
    chk("t2_drained", n_out - n0, 32'd4);
    chk("t2_last_pc", last_pc, 32'hC);

    // redirect with two fetches in flight on a 3-cycle imem
    lat = 3;
    do_reset();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("t3_inflight", pend_addr.size(), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    wait_out("t3_resume");
    chk("t3_first_pc", last_pc, 32'h100);
    chk("t3_first_instr", last_instr, mem_fn(32'h100));

    // redirect coinciding with a response, unaligned target
    lat = 1;
    do_reset();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    prep();
    chk1("t4_rsp_collides", bus.mem_rsp_valid, 1'b1);
    fin();
    bus.redirect_valid = 1'b0;
    prep();
    chk1("t4_req_valid", bus.mem_req_valid, 1'b1);
    chk("t4_req_addr", bus.mem_req_addr, 32'h200);
    fin();
    wait_out("t4_resume");
    chk("t4_first_pc", last_pc, 32'h200);

    // address wrap at the top of the space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    wait_out("t5_a");
    wait_out("t5_b");
    chk("t5_top_pc", last_pc, 32'hFFFF_FFFC);
    chk("t5_plus4_wrap", last_plus4, 32'h0);
    wait_out("t5_c");
    chk("t5_wrapped_pc", last_pc, 32'h0);

    // fetch-to-decode latency with an empty queue
    lat = 2;
    do_reset();
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      prep();
      if (bus.mem_rsp_valid) found = 1'b1;
      else fin();
    end
    chk1("t6_rsp_seen", found, 1'b1);
`ifdef FETCH_BYPASS_EN
    chk1("t6_bypass_valid", bus.out_valid, 1'b1);
    chk("t6_bypass_pc", bus.out_pc, 32'h0);
    chk("t6_bypass_instr", bus.out_instr, mem_fn(32'h0));
    fin();
`else
    chk1("t6_same_cycle_valid", bus.out_valid, 1'b0);
    fin();
    prep();
    chk1("t6_next_valid", bus.out_valid, 1'b1);
    chk("t6_next_pc", bus.out_pc, 32'h0);
    chk("t6_next_instr", bus.out_instr, mem_fn(32'h0));
    fin();
`endif

    // randomized stalls, imem backpressure and redirects
    for (int seg = 0; seg < 3; seg++) begin
      lat = seg + 1;
      do_reset();
      for (int i = 0; i < 500; i++) begin
        bus.out_ready      = ($urandom_range(3) != 0);
        bus.mem_req_ready  = ($urandom_range(4) != 0);
        bus.redirect_valid = ($urandom_range(24) == 0);
        bus.redirect_pc    = $urandom();
        if ($urandom_range(3) == 0) bus.redirect_pc = 32'hFFFF_FFE0 | ($urandom() & 32'h1F);
        tick();
      end
      bus.redirect_valid = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.out_ready      = 1'b1;
      wait_out("rand_live");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
